register_reader: RTL and testbench

Read-side port for the four-entry 8-bit register file. Takes read requests over a valid/ready handshake, snapshots the register file outputs, and returns data over a valid/ready response channel. Supports single reads and 4-beat wrapping bursts. Sits between the register file outputs (reg1..reg4) and any consumer that must not see torn or mid-update values.

---
 rtl/register_reader_if.sv | 26 ++
 rtl/register_reader.sv | 75 +++++++
 tb/tb_register_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/register_reader_if.sv
// register_reader_if: request/response channels of the register read port.
//   req_valid/req_ready/req_burst/req_id : request handshake (master drives valid, burst, id)
//   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_last : response beat handshake (master drives ready)
interface register_reader_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_burst;
    logic [1:0]        req_id;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_last;

    modport master (
        output req_valid, req_burst, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
    );

    modport slave (
        input  req_valid, req_burst, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
    );
endinterface

// File: rtl/register_reader.sv
// register_reader: snapshotting read port for a four-entry register file.
//   clk        : posedge clock (register file writes on negedge)
//   reset      : synchronous active-low reset
//   reg1..reg4 : register file outputs, entries 0..3
//   bus        : request/response channels (slave side)
//   beat_count : response beats accepted since reset, wraps mod 256
module register_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] reg3,
    input  logic [DATA_W-1:0] reg4,
    register_reader_if.slave  bus,
    output logic [7:0]        beat_count
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t                  state, state_nx;
    logic [3:0][DATA_W-1:0]  snap, snap_nx;
    logic [1:0]              idx, idx_nx;
    logic [1:0]              cnt, cnt_nx;
    logic                    burst, burst_nx;
    logic [7:0]              bc_nx;
    logic                    last;

    // Outputs are decoded from registered state only, so no input reaches them combinationally.
    assign last          = !burst || cnt == 2'd3;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = snap[idx];
    assign bus.rsp_id    = idx;
    assign bus.rsp_last  = state == RESP && last;

    always_comb begin
        state_nx = state;
        snap_nx  = snap;
        idx_nx   = idx;
        cnt_nx   = cnt;
        burst_nx = burst;
        bc_nx    = beat_count;
        if (state == IDLE && bus.req_valid) begin
            state_nx = RESP;
            snap_nx  = {reg4, reg3, reg2, reg1};
            idx_nx   = bus.req_id;
            cnt_nx   = 2'd0;
            burst_nx = bus.req_burst;
        end else if (state == RESP && bus.rsp_ready) begin
            bc_nx    = beat_count + 8'd1;
            state_nx = last ? IDLE : RESP;
            idx_nx   = last ? idx : idx + 2'd1;
            cnt_nx   = last ? cnt : cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            cnt        <= '0;
            burst      <= 1'b0;
            beat_count <= '0;
        end else begin
            state      <= state_nx;
            snap       <= snap_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            burst      <= burst_nx;
            beat_count <= bc_nx;
        end
    end
endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed bench with a beat-queue model checked every cycle.
module tb_register_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] regs [4];
    logic [7:0] beat_count;
    int         n_pass = 0;
    int         n_total = 0;

    register_reader_if bus ();

    register_reader dut (
        .clk(clk), .reset(reset),
        .reg1(regs[0]), .reg2(regs[1]), .reg3(regs[2]), .reg4(regs[3]),
        .bus(bus), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    bc = 0;
    bit    armed = 0;

    // Model: an accepted request expands into its list of beats, read from the register values at that edge.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            q.delete();
            bc = 0;
            armed = 1;
        end else if (q.size() != 0) begin
            if (bus.rsp_ready) begin
                void'(q.pop_front());
                bc = (bc + 1) % 256;
            end
        end else if (bus.req_valid) begin
            for (int k = 0; k < (bus.req_burst ? 4 : 1); k++) begin
                beat_t b;
                b.id   = bus.req_id + 2'(k);
                b.data = regs[b.id];
                b.last = k == (bus.req_burst ? 3 : 0);
                q.push_back(b);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("rsp_valid", int'(bus.rsp_valid), int'(q.size() != 0));
            check("req_ready", int'(bus.req_ready), int'(q.size() == 0));
            check("beat_count", int'(beat_count), bc);
            if (q.size() != 0) begin
                check("rsp_data", int'(bus.rsp_data), int'(q[0].data));
                check("rsp_id", int'(bus.rsp_id), int'(q[0].id));
                check("rsp_last", int'(bus.rsp_last), int'(q[0].last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the accepting edge, i.e. in the first beat's cycle.
    task automatic request(input logic burst, input logic [1:0] id);
        bit done = 0;
        bus.req_valid = 1'b1;
        bus.req_burst = burst;
        bus.req_id    = id;
        for (int t = 0; t < 20 && !done; t++) begin
            done = bus.req_ready;
            step();
        end
        bus.req_valid = 1'b0;
        if (!done) check("request_timeout", 0, 1);
    endtask

    initial begin
        logic [1:0] exp_id [4];
        logic [7:0] exp_dt [4];
        exp_id = '{2'd3, 2'd0, 2'd1, 2'd2};
        exp_dt = '{8'h44, 8'h11, 8'h22, 8'h33};
        regs = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.req_valid = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_id    = 2'd0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        check("reset_data", int'(bus.rsp_data), 0);
        check("reset_last", int'(bus.rsp_last), 0);
        reset = 1'b1;
        step();

        request(1'b0, 2'd2);
        check("single_data", int'(bus.rsp_data), 8'h33);
        check("single_id", int'(bus.rsp_id), 2);
        check("single_last", int'(bus.rsp_last), 1);
        step();
        check("single_count", int'(beat_count), 1);
        check("single_ready", int'(bus.req_ready), 1);

        request(1'b1, 2'd3);
        for (int k = 0; k < 4; k++) begin
            check("wrap_id", int'(bus.rsp_id), int'(exp_id[k]));
            check("wrap_data", int'(bus.rsp_data), int'(exp_dt[k]));
            check("wrap_last", int'(bus.rsp_last), int'(k == 3));
            step();
        end
        check("wrap_count", int'(beat_count), 5);

        request(1'b1, 2'd0);
        regs[1] = 8'hAA;
        step();
        check("snap_data", int'(bus.rsp_data), 8'h22);
        step();
        step();
        step();
        request(1'b0, 2'd1);
        check("snap_fresh", int'(bus.rsp_data), 8'hAA);
        step();
        regs[1] = 8'h22;

        request(1'b1, 2'd0);
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_id    = 2'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_data", int'(bus.rsp_data), 8'h22);
            check("bp_id", int'(bus.rsp_id), 1);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        step();
        check("bp_count", int'(beat_count), 14);

        request(1'b1, 2'd0);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_valid", int'(bus.rsp_valid), 0);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_count", int'(beat_count), 0);
        request(1'b0, 2'd0);
        check("rst_read", int'(bus.rsp_data), 8'h11);
        step();
        check("rst_count1", int'(beat_count), 1);

        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int b = 0; b < 64; b++) begin
            request(1'b1, 2'(b));
            repeat (4) step();
        end
        check("wrap256", int'(beat_count), 0);
        request(1'b0, 2'd3);
        step();
        check("wrap257", int'(beat_count), 1);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
